// File: rtl/counter.sv
// Free-running BW-bit up-counter that wraps modulo 2^BW and loads RST_VAL on synchronous reset.
// The first edge after reset release gives RST_VAL+1. There is no stall or backpressure.
module counter #(
  parameter int unsigned BW      = 3,
  parameter int unsigned RST_VAL = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [BW-1:0] counter_val_o
);

  localparam logic [BW-1:0] RST_V = BW'(RST_VAL);
  localparam logic [BW-1:0] ONE   = BW'(1);

  // Reset takes priority over the increment. The carry-out is dropped, so the count wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      counter_val_o <= RST_V;
    end else begin
      counter_val_o <= counter_val_o + ONE;
    end
  end

endmodule

// File: tb/tb_counter.sv
// Directed bench for the counter with three instances: the default BW=3, a BW=1 toggle, and RST_VAL=5.
module tb_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] val3;
  logic       val1;
  logic [2:0] val5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter #(3) u_cnt3 (
    .clk_i         (clk),
    .rst_i         (rst),
    .counter_val_o (val3)
  );

  counter #(.BW(1)) u_cnt1 (
    .clk_i         (clk),
    .rst_i         (rst),
    .counter_val_o (val1)
  );

  counter #(.BW(3), .RST_VAL(5)) u_cnt5 (
    .clk_i         (clk),
    .rst_i         (rst),
    .counter_val_o (val5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;

    // Hold reset for 5 edges. Outputs are sampled on the falling edge.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("rst3_%0d", i), {29'd0, val3}, 32'd0);
      check($sformatf("rst1_%0d", i), {31'd0, val1}, 32'd0);
      check($sformatf("rst5_%0d", i), {29'd0, val5}, 32'd5);
    end
    rst = 1'b0;   // released at t=50 ns

    // Edge k after release: BW=3 gives k mod 8, BW=1 gives k mod 2, RST_VAL=5 gives (5+k) mod 8.
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      check($sformatf("cnt3_%0d", k), {29'd0, val3}, 32'(k % 8));
      check($sformatf("cnt1_%0d", k), {31'd0, val1}, 32'(k % 2));
      check($sformatf("cnt5_%0d", k), {29'd0, val5}, 32'((5 + k) % 8));
    end
    check("final20_then5", {29'd0, val3}, 32'd5);

    // A single-edge reset mid-count takes effect on that same edge.
    rst = 1'b1;
    @(negedge clk);
    check("midrst3", {29'd0, val3}, 32'd0);
    check("midrst1", {31'd0, val1}, 32'd0);
    check("midrst5", {29'd0, val5}, 32'd5);
    rst = 1'b0;
    @(negedge clk);
    check("post3_1", {29'd0, val3}, 32'd1);
    check("post1_1", {31'd0, val1}, 32'd1);
    check("post5_1", {29'd0, val5}, 32'd6);
    @(negedge clk);
    check("post3_2", {29'd0, val3}, 32'd2);
    check("post1_2", {31'd0, val1}, 32'd0);
    check("post5_2", {29'd0, val5}, 32'd7);
    @(negedge clk);
    check("post5_wrap", {29'd0, val5}, 32'd0);
    check("post1_3", {31'd0, val1}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
